// File: rtl/uart_stim_tx_if.sv
// Byte-write port of the UART stimulus transmitter: data/strobe in, FIFO status back.
// tx_wr is a one-cycle strobe with no back-pressure: a byte offered while tx_full
// (and no pop that cycle) is dropped and reported through the sticky overflow flag.
interface uart_stim_tx_if;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_full;
  logic       tx_empty;
  logic       overflow;

  modport slave (
    input  tx_data,
    input  tx_wr,
    output tx_full,
    output tx_empty,
    output overflow
  );

  modport master (
    output tx_data,
    output tx_wr,
    input  tx_full,
    input  tx_empty,
    input  overflow
  );
endinterface

// File: rtl/uart_stim_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; bit period is 16*divisor clocks, latched per frame.
// FSM state is exported on dbg_state (IDLE=0, START=1, DATA=2, STOP=3).
module uart_stim_tx #(
  parameter int FIFO_AW = 4
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n_i,
  input  logic [15:0]   divisor,
  uart_stim_tx_if.slave wr_bus,
  output logic          tx_busy,
  output logic          tx_done,
  output logic          txd,
  output logic [1:0]    dbg_state
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t             state, state_d;
  logic [7:0]         mem [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               fifo_full, fifo_empty, push, pop;
  logic               overflow_q;
  logic [19:0]        baud_cnt, baud_d, bit_len;
  logic [15:0]        div_q, div_d, div_eff;
  logic [2:0]         bit_idx, bit_idx_d;
  logic [7:0]         shreg, shreg_d;
  logic               txd_d, bit_end, start_frame;

  // Occupancy never exceeds the depth, so the MSB alone marks full.
  assign fifo_full       = count[FIFO_AW];
  assign fifo_empty      = (count == '0);
  assign wr_bus.tx_full  = fifo_full;
  assign wr_bus.tx_empty = fifo_empty;
  assign wr_bus.overflow = overflow_q;

  assign div_eff     = (divisor == 16'd0) ? 16'd1 : divisor;
  assign bit_len     = {div_q, 4'b0000};
  assign bit_end     = (baud_cnt == bit_len - 20'd1);
  assign start_frame = !fifo_empty && ((state == S_IDLE) || (state == S_STOP && bit_end));
  assign pop         = start_frame;
  assign push        = wr_bus.tx_wr && (!fifo_full || pop);

  assign tx_busy   = (state != S_IDLE);
  assign tx_done   = (state == S_STOP) && bit_end;
  assign dbg_state = state;

  always_comb begin
    state_d   = state;
    baud_d    = baud_cnt + 20'd1;
    bit_idx_d = bit_idx;
    txd_d     = txd;
    shreg_d   = shreg;
    div_d     = div_q;
    unique case (state)
      S_IDLE: begin
        baud_d = '0;
        txd_d  = 1'b1;
      end
      S_START: begin
        if (bit_end) begin
          state_d   = S_DATA;
          baud_d    = '0;
          bit_idx_d = '0;
          txd_d     = shreg[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shreg_d = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            txd_d     = shreg[1];
          end
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          baud_d  = '0;
          txd_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A pending byte starts the next frame straight out of IDLE or the last stop clock.
    if (start_frame) begin
      state_d   = S_START;
      baud_d    = '0;
      bit_idx_d = '0;
      txd_d     = 1'b0;
      shreg_d   = mem[rd_ptr];
      div_d     = div_eff;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state      <= S_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      txd        <= 1'b1;
      shreg      <= '0;
      div_q      <= 16'd1;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_idx_d;
      txd      <= txd_d;
      shreg    <= shreg_d;
      div_q    <= div_d;
      if (push) wr_ptr <= wr_ptr + (FIFO_AW)'(1);
      if (pop)  rd_ptr <= rd_ptr + (FIFO_AW)'(1);
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: ;
      endcase
      if (wr_bus.tx_wr && !push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= wr_bus.tx_data;
  end
endmodule

// File: doc/uart_stim_tx.md
UART_STIM_TX -- requirements
Module: uart_stim_tx

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, meaning the log2 of the FIFO depth (16 entries).
REQ-002 SHALL have port wb_clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port divisor, input, 16 bits: oversample divisor; bit period = 16*divisor clocks.
REQ-005 SHALL have port tx_data, input, 8 bits: byte to enqueue.
REQ-006 SHALL have port tx_wr, input, 1 bit: enqueue strobe, one byte per cycle high.
REQ-007 SHALL have port tx_full, output, 1 bit: FIFO holds 2**FIFO_AW bytes.
REQ-008 SHALL have port tx_empty, output, 1 bit: FIFO holds 0 bytes.
REQ-009 SHALL have port tx_busy, output, 1 bit: a frame is on the line.
REQ-010 SHALL have port tx_done, output, 1 bit: one-cycle pulse at the end of each stop bit.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, set by a write that was dropped.
REQ-012 SHALL have port txd, output, 1 bit: registered serial line, idle high.

Function
REQ-013 SHALL frame each byte 8N1: one start bit (0), data bits LSB first, one stop bit (1).
REQ-014 SHALL hold every bit for exactly 16*divisor clocks; divisor 0 SHALL be treated as 1.
REQ-015 SHALL latch divisor at frame start; changes mid-frame SHALL NOT affect the current frame.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP.
  - IDLE->START: when the FIFO is not empty; pop the head byte.
  - START->DATA: after one bit period.
  - DATA->STOP: after 8 bit periods; a 3-bit counter indexes the data bit.
  - STOP->START: if the FIFO is not empty; otherwise STOP->IDLE.
REQ-017 SHALL give a write at edge N into an empty FIFO while IDLE: FIFO updated at edge N, txd=0 from edge N+1.
REQ-018 SHALL send back-to-back frames with no idle gap: the next start bit begins on the clock after the stop bit ends.
REQ-019 SHALL assert tx_done for exactly one cycle, coincident with the stop bit's last clock; txd SHALL remain 1 through it.
REQ-020 SHALL assert tx_busy from the first start-bit clock through the last stop-bit clock, continuously across back-to-back frames.
REQ-021 SHALL drop tx_wr while full with no pop that cycle: FIFO unchanged, overflow set.
REQ-022 SHALL accept the write when tx_wr coincides with a pop while full; occupancy SHALL be unchanged.
REQ-023 SHALL perform both operations when tx_wr coincides with a pop on a non-empty, non-full FIFO; occupancy SHALL be unchanged.
REQ-024 SHALL wrap FIFO pointers modulo 2**FIFO_AW; occupancy counter SHALL be FIFO_AW+1 bits.
REQ-025 SHALL clear overflow only by reset.
REQ-026 SHALL derive tx_full and tx_empty combinationally from the occupancy counter.

Reset
REQ-027 SHALL, on wb_rst_n_i low, immediately set: txd=1, tx_busy=0, tx_done=0, overflow=0, tx_empty=1, tx_full=0, FSM=IDLE, FIFO pointers and count 0, bit and baud counters 0.
REQ-028 SHALL abort any frame in progress on reset: txd returns to 1 asynchronously and FIFO contents are discarded.
REQ-029 SHALL start from IDLE after wb_rst_n_i deasserts; writes are accepted from the first clock edge with reset high.

Verification
REQ-030 SHALL cover single byte: divisor=1, write 0x55 -> txd sequence 0,1,0,1,0,1,0,1,0,1, each 16 clocks; tx_done on clock 160 of the frame.
REQ-031 SHALL cover back-to-back: divisor=2, write 0x00 then 0xFF on consecutive cycles -> two 320-clock frames, no gap, tx_busy high for 640 clocks, two tx_done pulses.
REQ-032 SHALL cover overflow: divisor=100, write 18 bytes in consecutive cycles -> 17 accepted (one already popped), 18th dropped, overflow=1, 17 frames sent.
REQ-033 SHALL cover simultaneous push/pop when full: FIFO full, write coinciding with the STOP->START pop -> byte accepted, overflow stays 0, tx_full stays 1.
REQ-034 SHALL cover reset mid-frame: assert wb_rst_n_i during DATA -> txd=1 without waiting for a clock, tx_empty=1; after release and write 0xA5 -> correct frame 0,1,0,1,0,0,1,0,1,1.
REQ-035 SHALL cover loopback: txd to the bench receiver (divisor 80) -> decoded bytes equal the written bytes in order.
